decode_stage: RTL and testbench

//  Registered, handshaked successor of the combinational decoder for the 16-bit SIMPLE ISA.
//  - Sits between fetch and execute. Decodes one instruction word into control fields.
//  - Holds them in an output register with valid/ready flow control.
//  - Keeps a per-register pending-write scoreboard and stalls on RAW/WAW hazards.
//  - Supports flush (taken branch) and a sticky HALT state.

---
 rtl/decode_stage_pkg.sv | 96 +++++++++
 rtl/decode_stage_if.sv | 46 ++++
 rtl/decode_stage_comb.sv | 97 +++++++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the SIMPLE 16-bit ISA decode stage: field positions,
// opcode/op3/cond encodings, the decoded control bundle and the FSM state type.
package decode_stage_pkg;

    localparam int ISA_W      = 16;
    localparam int ISA_NREG   = 8;
    localparam int ISA_REG_AW = 3;

    // instruction field positions (within the 16-bit ISA word)
    localparam int F_OP_HI  = 15;
    localparam int F_OP_LO  = 14;
    localparam int F_RA_HI  = 13;
    localparam int F_RA_LO  = 11;
    localparam int F_RB_HI  = 10;
    localparam int F_RB_LO  = 8;
    localparam int F_OP3_HI = 7;
    localparam int F_OP3_LO = 4;

    // major opcode [15:14]
    localparam logic [1:0] OP_LD    = 2'b00;
    localparam logic [1:0] OP_ST    = 2'b01;
    localparam logic [1:0] OP_IMM   = 2'b10;
    localparam logic [1:0] OP_ARITH = 2'b11;

    // op2 sub-opcode [13:11] when the major opcode is OP_IMM
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // ALU / op3 encodings
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_CMP  = 4'b0101;
    localparam logic [3:0] ALU_MOV  = 4'b0110;
    localparam logic [3:0] ALU_NOP7 = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLR  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_IN   = 4'b1100;
    localparam logic [3:0] ALU_OUT  = 4'b1101;
    localparam logic [3:0] ALU_NOPE = 4'b1110;
    localparam logic [3:0] ALU_HLT  = 4'b1111;

    localparam logic [2:0] COND_ALWAYS = 3'b000;

    // fields presented to execute
    typedef struct packed {
        logic [ISA_REG_AW-1:0] ar;
        logic [ISA_REG_AW-1:0] br;
        logic [ISA_REG_AW-1:0] wadr;
        logic                  we;
        logic [3:0]            s_alu;
        logic                  se;
        logic [ISA_W-1:0]      imm;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  br_en;
        logic [2:0]            cond;
    } ctl_t;

    // control fields plus what the stage itself needs for hazards and HALT
    typedef struct packed {
        ctl_t ctl;
        logic use_a;
        logic use_b;
        logic halt_op;
    } bundle_t;

    localparam int CTL_W = $bits(ctl_t);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HALTED  = 1'b1
    } state_t;

    function automatic logic [ISA_W-1:0] sext4(input logic [3:0] d);
        return {{(ISA_W-4){d[3]}}, d};
    endfunction

    function automatic logic [ISA_W-1:0] zext4(input logic [3:0] d);
        return {{(ISA_W-4){1'b0}}, d};
    endfunction

    function automatic logic [ISA_W-1:0] sext8(input logic [7:0] d);
        return {{(ISA_W-8){d[7]}}, d};
    endfunction

    function automatic logic is_shift(input logic [3:0] op3);
        return op3[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake buses on either side of the decode stage: fetch->decode carries the
// raw instruction, decode->execute carries the decoded control bundle.
interface fetch_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [PC_W-1:0]   if_pc;

    modport master (output if_valid, if_instr, if_pc, input if_ready);
    modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

interface id_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int REG_AW = 3
);
    logic              id_valid;
    logic              id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [REG_AW-1:0] ar;
    logic [REG_AW-1:0] br;
    logic [REG_AW-1:0] wadr;
    logic              we;
    logic [3:0]        s_alu;
    logic              se;
    logic [DATA_W-1:0] imm;
    logic              mem_rd;
    logic              mem_wr;
    logic              br_en;
    logic [2:0]        cond;

    modport master (
        output id_valid, id_pc, ar, br, wadr, we, s_alu, se, imm,
               mem_rd, mem_wr, br_en, cond,
        input  id_ready
    );
    modport slave (
        input  id_valid, id_pc, ar, br, wadr, we, s_alu, se, imm,
               mem_rd, mem_wr, br_en, cond,
        output id_ready
    );
endinterface

// File: rtl/decode_stage_comb.sv
// Pure combinational field decode of one SIMPLE instruction word into the
// control bundle, including which register fields are real operands.
module decode_comb
    import decode_stage_pkg::*;
(
    input  logic [ISA_W-1:0] instr,
    output bundle_t          dec
);

    logic [1:0]            op;
    logic [ISA_REG_AW-1:0] fa;
    logic [ISA_REG_AW-1:0] fb;
    logic [3:0]            op3;

    assign op  = instr[F_OP_HI:F_OP_LO];
    assign fa  = instr[F_RA_HI:F_RA_LO];
    assign fb  = instr[F_RB_HI:F_RB_LO];
    assign op3 = instr[F_OP3_HI:F_OP3_LO];

    // decode by major opcode; anything unlisted falls out as an all-zero NOP
    always_comb begin
        dec = '0;
        unique case (op)
            OP_ARITH: begin
                dec.ctl.ar    = fa;
                dec.ctl.br    = fb;
                dec.ctl.wadr  = fb;
                dec.ctl.s_alu = op3;
                if (is_shift(op3)) begin
                    dec.ctl.se  = 1'b1;
                    dec.ctl.imm = zext4(instr[3:0]);
                end else begin
                    dec.ctl.imm = sext4(instr[3:0]);
                end
                case (op3)
                    ALU_IN:  dec.ctl.we = 1'b1;
                    ALU_OUT: dec.use_a = 1'b1;
                    ALU_CMP: begin
                        dec.use_a = 1'b1;
                        dec.use_b = 1'b1;
                    end
                    ALU_HLT: dec.halt_op = 1'b1;
                    ALU_NOP7, ALU_NOPE: ;
                    default: begin
                        dec.ctl.we = 1'b1;
                        dec.use_a  = 1'b1;
                        dec.use_b  = 1'b1;
                    end
                endcase
            end
            OP_LD: begin
                dec.ctl.wadr   = fa;
                dec.ctl.br     = fb;
                dec.ctl.we     = 1'b1;
                dec.ctl.mem_rd = 1'b1;
                dec.ctl.se     = 1'b1;
                dec.ctl.s_alu  = ALU_ADD;
                dec.ctl.imm    = sext8(instr[7:0]);
                dec.use_b      = 1'b1;
            end
            OP_ST: begin
                dec.ctl.ar     = fa;
                dec.ctl.br     = fb;
                dec.ctl.mem_wr = 1'b1;
                dec.ctl.se     = 1'b1;
                dec.ctl.s_alu  = ALU_ADD;
                dec.ctl.imm    = sext8(instr[7:0]);
                dec.use_a      = 1'b1;
                dec.use_b      = 1'b1;
            end
            OP_IMM: begin
                case (fa)
                    OP2_LI: begin
                        dec.ctl.wadr = fb;
                        dec.ctl.we   = 1'b1;
                        dec.ctl.se   = 1'b1;
                        dec.ctl.imm  = sext8(instr[7:0]);
                    end
                    OP2_B: begin
                        dec.ctl.br_en = 1'b1;
                        dec.ctl.cond  = COND_ALWAYS;
                        dec.ctl.se    = 1'b1;
                        dec.ctl.imm   = sext8(instr[7:0]);
                    end
                    OP2_BCC: begin
                        dec.ctl.br_en = 1'b1;
                        dec.ctl.cond  = fb;
                        dec.ctl.se    = 1'b1;
                        dec.ctl.imm   = sext8(instr[7:0]);
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-entry output register with valid/ready flow
// control, pending-write scoreboard for RAW/WAW stalls, flush and sticky HALT.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_RUN     | normal operation, instructions accepted when legal
//   ST_HALTED  | HLT accepted; fetch blocked until flush or reset
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    fetch_if.slave            fetch,
    id_if.master              id,
    input  logic              flush,
    output logic              halt,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_adr
);

    bundle_t         dec;
    ctl_t            held_q;
    logic [PC_W-1:0] pc_q;
    logic            id_valid_q;
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_set;
    logic [NREG-1:0] sb_clr;
    logic            hazard;
    logic            if_ready_c;
    logic            accept;
    state_t          state_q;
    state_t          state_d;

    decode_comb u_decode_comb (
        .instr (fetch.if_instr[DATA_W-1 -: ISA_W]),
        .dec   (dec)
    );

    assign hazard = (dec.use_a  & sb_q[dec.ctl.ar])
                  | (dec.use_b  & sb_q[dec.ctl.br])
                  | (dec.ctl.we & sb_q[dec.ctl.wadr]);

    assign accept = fetch.if_valid & if_ready_c;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and fetch-side ready
    always_comb begin
        state_d    = state_q;
        if_ready_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if_ready_c = ~hazard & (~id_valid_q | id.id_ready) & ~flush;
                if (fetch.if_valid && if_ready_c && dec.halt_op) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (flush) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // scoreboard set/clear requests; a flushed held writer releases its destination
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (accept && dec.ctl.we) begin
            sb_set[dec.ctl.wadr] = 1'b1;
        end
        if (wb_valid) begin
            sb_clr[wb_adr] = 1'b1;
        end
        if (flush && id_valid_q && held_q.we) begin
            sb_clr[held_q.wadr] = 1'b1;
        end
    end

    // scoreboard update, set wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= (sb_q & ~sb_clr) | sb_set;
        end
    end

    // output register: flush kills, accept loads, consume empties, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            held_q     <= '0;
            pc_q       <= '0;
        end else if (flush) begin
            id_valid_q <= 1'b0;
        end else if (accept) begin
            id_valid_q <= 1'b1;
            held_q     <= dec.ctl;
            pc_q       <= fetch.if_pc;
        end else if (id.id_ready) begin
            id_valid_q <= 1'b0;
        end
    end

    assign fetch.if_ready = if_ready_c;
    assign halt           = (state_q == ST_HALTED);

    assign id.id_valid = id_valid_q;
    assign id.id_pc    = pc_q;
    assign id.ar       = held_q.ar;
    assign id.br       = held_q.br;
    assign id.wadr     = held_q.wadr;
    assign id.we       = held_q.we;
    assign id.s_alu    = held_q.s_alu;
    assign id.se       = held_q.se;
    assign id.imm      = DATA_W'($signed(held_q.imm));
    assign id.mem_rd   = held_q.mem_rd;
    assign id.mem_wr   = held_q.mem_wr;
    assign id.br_en    = held_q.br_en;
    assign id.cond     = held_q.cond;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then random traffic,
// every cycle compared against an instruction-level reference model.
module tb_decode_stage;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
    localparam int PC_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              halt;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_adr;

    fetch_if #(.DATA_W(DATA_W), .PC_W(PC_W)) fetch_bus ();
    id_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW)) id_bus ();

    decode_stage #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW),
        .PC_W   (PC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch    (fetch_bus),
        .id       (id_bus),
        .flush    (flush),
        .halt     (halt),
        .wb_valid (wb_valid),
        .wb_adr   (wb_adr)
    );

    always #5 clk = ~clk;

    // expected decode of one instruction plus the set of registers it reads
    typedef struct packed {
        logic [2:0]  ar;
        logic [2:0]  br;
        logic [2:0]  wadr;
        logic        we;
        logic [3:0]  s_alu;
        logic        se;
        logic [15:0] imm;
        logic        mem_rd;
        logic        mem_wr;
        logic        br_en;
        logic [2:0]  cond;
        logic        hlt;
        logic [7:0]  reads;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit [7:0]    pend;
    bit          halted;
    bit          held_v;
    exp_t        held;
    logic [15:0] held_pc;
    int          wbq[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    endtask

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic exp_t ref_decode(input logic [15:0] w);
        exp_t e;
        int   f;
        int   d4;
        int   d8;
        e  = '0;
        f  = int'(w[7:4]);
        d4 = int'(w[3:0]);
        d8 = int'(w[7:0]);
        case (w[15:14])
            2'b11: begin
                e.ar    = w[13:11];
                e.br    = w[10:8];
                e.wadr  = w[10:8];
                e.s_alu = w[7:4];
                if (f >= 8 && f <= 11) begin
                    e.se  = 1'b1;
                    e.imm = 16'(d4);
                end else begin
                    e.imm = 16'(sx(d4, 4));
                end
                if (f == 12) e.we = 1'b1;
                else if (f == 13) e.reads[w[13:11]] = 1'b1;
                else if (f == 5) begin
                    e.reads[w[13:11]] = 1'b1;
                    e.reads[w[10:8]]  = 1'b1;
                end else if (f == 15) e.hlt = 1'b1;
                else if (f != 7 && f != 14) begin
                    e.we = 1'b1;
                    e.reads[w[13:11]] = 1'b1;
                    e.reads[w[10:8]]  = 1'b1;
                end
            end
            2'b00: begin
                e.wadr   = w[13:11];
                e.br     = w[10:8];
                e.we     = 1'b1;
                e.mem_rd = 1'b1;
                e.se     = 1'b1;
                e.imm    = 16'(sx(d8, 8));
                e.reads[w[10:8]] = 1'b1;
            end
            2'b01: begin
                e.ar     = w[13:11];
                e.br     = w[10:8];
                e.mem_wr = 1'b1;
                e.se     = 1'b1;
                e.imm    = 16'(sx(d8, 8));
                e.reads[w[13:11]] = 1'b1;
                e.reads[w[10:8]]  = 1'b1;
            end
            default: begin
                if (w[13:11] == 3'd0) begin
                    e.wadr = w[10:8];
                    e.we   = 1'b1;
                    e.se   = 1'b1;
                    e.imm  = 16'(sx(d8, 8));
                end else if (w[13:11] == 3'd4 || w[13:11] == 3'd7) begin
                    e.br_en = 1'b1;
                    e.cond  = (w[13:11] == 3'd7) ? w[10:8] : 3'd0;
                    e.se    = 1'b1;
                    e.imm   = 16'(sx(d8, 8));
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] dut_bundle();
        return 64'({id_bus.ar, id_bus.br, id_bus.wadr, id_bus.we, id_bus.s_alu, id_bus.se,
                    id_bus.imm, id_bus.mem_rd, id_bus.mem_wr, id_bus.br_en, id_bus.cond});
    endfunction

    function automatic logic [63:0] exp_bundle(input exp_t e);
        return 64'({e.ar, e.br, e.wadr, e.we, e.s_alu, e.se,
                    e.imm, e.mem_rd, e.mem_wr, e.br_en, e.cond});
    endfunction

    // one clock cycle: called at a falling edge, returns at the next falling edge
    task automatic step(input bit v, input logic [15:0] ins, input bit rdy,
                        input bit fl, input bit wv, input logic [2:0] wa);
        exp_t        e;
        bit [7:0]    touch;
        bit          exp_rdy;
        bit          acc;
        logic [15:0] pc;
        pc = 16'($urandom);
        fetch_bus.if_valid = v;
        fetch_bus.if_instr = ins;
        fetch_bus.if_pc    = pc;
        id_bus.id_ready    = rdy;
        flush              = fl;
        wb_valid           = wv;
        wb_adr             = wa;
        #1;
        e     = ref_decode(ins);
        touch = e.reads;
        if (e.we) touch[e.wadr] = 1'b1;
        exp_rdy = !halted && ((touch & pend) == 8'd0) && (!held_v || rdy) && !fl;
        check_val("if_ready", 64'(fetch_bus.if_ready), 64'(exp_rdy));
        check_val("id_valid", 64'(id_bus.id_valid), 64'(held_v));
        check_val("halt", 64'(halt), 64'(halted));
        if (held_v) begin
            check_val("bundle", dut_bundle(), exp_bundle(held));
            check_val("id_pc", 64'(id_bus.id_pc), 64'(held_pc));
        end
        acc = v && exp_rdy;
        if (wv) begin
            pend[wa] = 1'b0;
            for (int i = 0; i < wbq.size(); i++) begin
                if (wbq[i] == int'(wa)) begin
                    wbq.delete(i);
                    break;
                end
            end
        end
        if (fl && held_v && held.we) pend[held.wadr] = 1'b0;
        if (acc && e.we) pend[e.wadr] = 1'b1;
        if (held_v && rdy && !fl && held.we) wbq.push_back(int'(held.wadr));
        if (fl) held_v = 1'b0;
        else if (acc) begin
            held_v  = 1'b1;
            held    = e;
            held_pc = pc;
        end else if (rdy) held_v = 1'b0;
        if (halted) begin
            if (fl) halted = 1'b0;
        end else if (acc && e.hlt) halted = 1'b1;
        @(negedge clk);
    endtask

    // called at a falling edge; holds reset across one rising edge
    task automatic do_reset();
        rst                = 1'b1;
        fetch_bus.if_valid = 1'b0;
        flush              = 1'b0;
        wb_valid           = 1'b0;
        #1;
        check_val("rst_id_valid", 64'(id_bus.id_valid), 64'd0);
        check_val("rst_halt", 64'(halt), 64'd0);
        check_val("rst_bundle", dut_bundle(), 64'd0);
        check_val("rst_id_pc", 64'(id_bus.id_pc), 64'd0);
        pend   = '0;
        halted = 1'b0;
        held_v = 1'b0;
        wbq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [15:0] I_ADD75  = 16'b11_111_101_0000_1111;
    localparam logic [15:0] I_LD25   = 16'b00_010_101_0000_0000;
    localparam logic [15:0] I_ADD23  = 16'b11_010_011_0000_0000;
    localparam logic [15:0] I_AND14  = 16'b11_001_100_0010_0000;
    localparam logic [15:0] I_SUB67  = 16'b11_110_111_0001_0000;
    localparam logic [15:0] I_BCC3   = 16'b10_111_011_1111_0101;
    localparam logic [15:0] I_LI1    = 16'b10_000_001_1000_0010;
    localparam logic [15:0] I_HLT    = 16'b11_000_000_1111_0000;
    localparam logic [15:0] I_SLL    = 16'b11_100_110_1000_1101;
    localparam logic [15:0] I_LD01   = 16'b00_000_001_0000_0100;
    localparam logic [15:0] I_ADD02  = 16'b11_000_010_0000_0000;

    initial begin
        rst                = 1'b1;
        fetch_bus.if_valid = 1'b0;
        fetch_bus.if_instr = '0;
        fetch_bus.if_pc    = '0;
        id_bus.id_ready    = 1'b0;
        flush              = 1'b0;
        wb_valid           = 1'b0;
        wb_adr             = '0;
        pend               = '0;
        halted             = 1'b0;
        held_v             = 1'b0;
        held               = '0;
        held_pc            = '0;
        @(negedge clk);
        do_reset();

        // ADD r7,r5 decoded one cycle after acceptance
        step(1, I_ADD75, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd5);

        // LD r2 then a dependent ADD held until r2 is written back
        step(1, I_LD25, 1, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(1, I_ADD23, 1, 0, 0, 3'd0);
        step(1, I_ADD23, 1, 0, 1, 3'd2);
        step(1, I_ADD23, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd3);

        // AND held under back-pressure for five cycles
        step(1, I_AND14, 0, 0, 0, 3'd0);
        for (int i = 0; i < 5; i++) step(1, I_SUB67, 0, 0, 0, 3'd0);
        step(1, I_SUB67, 1, 0, 0, 3'd0);
        step(1, I_SLL, 1, 0, 1, 3'd1);
        step(0, 16'h0000, 1, 0, 1, 3'd6);
        step(0, 16'h0000, 1, 0, 1, 3'd6);

        // held Bcc killed by flush, then fetch resumes
        step(1, I_BCC3, 0, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 1, 0, 3'd0);
        step(1, I_LI1, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd1);

        // HLT halts fetch until flush
        step(1, I_HLT, 1, 0, 0, 3'd0);
        for (int i = 0; i < 10; i++) step(1, I_SUB67, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 1, 0, 3'd0);
        step(1, I_SUB67, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 1, 3'd7);

        // reset in the middle of a RAW stall, then LD r0 accepted immediately
        step(1, I_LD01, 1, 0, 0, 3'd0);
        step(1, I_ADD02, 1, 0, 0, 3'd0);
        step(1, I_ADD02, 0, 0, 0, 3'd0);
        do_reset();
        step(1, I_LD01, 1, 0, 0, 3'd0);
        step(0, 16'h0000, 1, 0, 0, 3'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bit          v;
            bit          rdy;
            bit          fl;
            bit          wv;
            logic [2:0]  wa;
            logic [15:0] ins;
            if (c == 1500) do_reset();
            v   = ($urandom_range(3) != 0);
            ins = 16'($urandom);
            rdy = ($urandom_range(3) != 0);
            fl  = ($urandom_range(19) == 0);
            wv  = 1'b0;
            wa  = 3'($urandom);
            if (wbq.size() > 0 && $urandom_range(1) == 0) begin
                wv = 1'b1;
                wa = 3'(wbq[0]);
            end else if ($urandom_range(31) == 0) begin
                wv = 1'b1;
            end
            step(v, ins, rdy, fl, wv, wa);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
